// File: rtl/pulse_receiver_if.sv
// Connection bundle between the upstream pulse generator (master) and the
// serial frame receiver (slave).
interface pulse_receiver_if #(
  parameter int WIDTH = 16
);
  localparam int ONES_W = $clog2(WIDTH + 1);

  logic              serial_in;
  logic              frame_start;
  logic [WIDTH-1:0]  data_out;
  logic              data_valid;
  logic [ONES_W-1:0] ones_count;
  logic              busy;
  logic              frame_error;

  modport master (
    output serial_in, frame_start,
    input  data_out, data_valid, ones_count, busy, frame_error
  );

  modport slave (
    input  serial_in, frame_start,
    output data_out, data_valid, ones_count, busy, frame_error
  );
endinterface

// File: rtl/pulse_receiver.sv
// Serial frame receiver: shifts WIDTH bits in after a frame_start, then
// publishes the word, its population count and a one-cycle valid pulse.
module pulse_receiver #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  pulse_receiver_if.slave  bus
);

  localparam int CNT_W  = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam int ONES_W = $clog2(WIDTH + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_count;
  logic [WIDTH-2:0]  r_part;
  logic [WIDTH-1:0]  r_data;
  logic [ONES_W-1:0] r_ones;
  logic              r_valid;
  logic              r_error;

  logic [WIDTH-1:0]  w_next;
  logic [WIDTH-2:0]  w_part_next;
  logic [ONES_W-1:0] w_ones;
  logic              w_last;

  // Only WIDTH-1 bits of history are needed: the final bit goes straight
  // from serial_in into the published word.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_next      = {r_part, bus.serial_in};
      assign w_part_next = w_next[WIDTH-2:0];
    end else begin : g_lsb
      assign w_next      = {bus.serial_in, r_part};
      assign w_part_next = w_next[WIDTH-1:1];
    end
  endgenerate

  // NOTE: every always_comb output gets a default before the loop, so no latch is inferred.
  always_comb begin
    w_ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_ones = w_ones + ONES_W'(w_next[i]);
    end
  end

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_part  <= '0;
      r_data  <= '0;
      r_ones  <= '0;
      r_valid <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.frame_start) begin
            r_state <= S_SHIFT;
            r_count <= '0;
            r_part  <= '0;
          end
        end
        S_SHIFT: begin
          // The completing edge wins over a simultaneous frame_start.
          if (w_last) begin
            r_data  <= w_next;
            r_ones  <= w_ones;
            r_valid <= 1'b1;
            r_part  <= w_part_next;
            r_state <= S_IDLE;
          end else if (bus.frame_start) begin
            r_error <= 1'b1;
            r_count <= '0;
            r_part  <= '0;
          end else begin
            r_part  <= w_part_next;
            r_count <= r_count + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.data_out    = r_data;
  assign bus.ones_count  = r_ones;
  assign bus.data_valid  = r_valid;
  assign bus.frame_error = r_error;
  assign bus.busy        = (r_state == S_SHIFT);

endmodule

// File: doc/pulse_receiver.md
PULSE_RECEIVER -- requirements
Module: pulse_receiver

Interface
REQ-001 Parameter WIDTH, default 16, number of serial bits per frame; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = first received bit lands in data_out[WIDTH-1], 0 = first received bit lands in data_out[0].
REQ-003 clock  input  1  single system clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to clock.
REQ-005 serial_in  input  1  serial bit stream from the upstream pulse generator, one bit per clock.
REQ-006 frame_start  input  1  level from the generator's load control, sampled high = a new frame begins on the next clock.
REQ-007 data_out  output  WIDTH  last completely received frame, held until the next frame completes.
REQ-008 data_valid  output  1  one-cycle pulse, data_out updated this cycle.
REQ-009 ones_count  output  $clog2(WIDTH+1)  number of 1 bits in data_out, updated together with data_out.
REQ-010 busy  output  1  high while a frame is being shifted in.
REQ-011 frame_error  output  1  one-cycle pulse, a frame was aborted by an early frame_start.

Function
REQ-012 State machine SHALL have exactly two states: IDLE and SHIFT.
REQ-013 IDLE: frame_start=1 at rising edge -> SHIFT, bit counter cleared to 0, shift register cleared; serial_in at that same edge is NOT captured.
REQ-014 SHIFT: each rising edge SHALL capture serial_in and increment the bit counter; frame_start=0 during capture.
REQ-015 With frame_start seen at edge N, bits SHALL be sampled at edges N+1 .. N+WIDTH.
REQ-016 At edge N+WIDTH: data_out and ones_count SHALL load the assembled word; data_valid SHALL be 1 for exactly the following cycle; state SHALL return to IDLE.
REQ-017 Latency: data_valid asserted exactly WIDTH cycles after the frame_start edge; a back-to-back frame_start at edge N+WIDTH+1 SHALL be accepted with no lost cycle.
REQ-018 frame_start=1 sampled in SHIFT before edge N+WIDTH: partial word discarded, frame_error pulses one cycle, counter restarts at 0, state stays SHIFT (that edge is treated as a new edge N); data_out unchanged.
REQ-019 frame_start=1 at the completing edge N+WIDTH: the frame completes normally (REQ-016) and the new frame_start is ignored; no frame_error.
REQ-020 busy SHALL equal (state == SHIFT).
REQ-021 ones_count SHALL be computed from the assembled word, not accumulated across frames; range 0..WIDTH, no wrap.
REQ-022 data_valid and frame_error SHALL never be high in the same cycle.

Reset
REQ-023 reset low SHALL asynchronously force: state IDLE, counter 0, shift register 0, data_out 0, ones_count 0, data_valid 0, busy 0, frame_error 0.
REQ-024 reset asserted mid-frame SHALL discard the partial frame with no data_valid and no frame_error pulse.
REQ-025 First frame_start SHALL be honoured on the first rising edge after reset returns high.

Verification
REQ-026 WIDTH=16, MSB_FIRST=1: frame_start pulse, then serial 0101001001010100 MSB first -> data_out=16'h5254, ones_count=6, data_valid high one cycle exactly 16 cycles after the frame_start edge.
REQ-027 MSB_FIRST=0, same bit sequence -> data_out=16'h2A4A, ones_count=6.
REQ-028 Two frames back-to-back (16'hFFFF then 16'h0000, frame_start on the cycle after data_valid) -> data_valid twice, 17 cycles apart; ones_count 16 then 0.
REQ-029 frame_start re-asserted after 7 bits -> frame_error one cycle, no data_valid, data_out keeps previous value; the following full 16-bit frame is received correctly.
REQ-030 reset driven low after 10 bits, mid-clock -> all outputs 0 immediately, no data_valid; after release, a frame of 16'h8001 yields data_out=16'h8001, ones_count=2.
REQ-031 frame_start held high at the completing edge -> normal data_valid, no frame_error, busy=0 next cycle.
